// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-Lite initiator: turns a local command/response
// handshake into one AXI-Lite read or write at a time, with a sticky stall flag.
module axi_lite_master #(
  parameter int C_M_AXI_LITE_ADDR_WIDTH = 10,
  parameter int C_M_AXI_LITE_DATA_WIDTH = 32,
  parameter int C_TIMEOUT_CYCLES        = 1024
) (
  input  logic                                   m_axi_lite_aclk,
  input  logic                                   axi_resetn,
  // local command/response port
  input  logic                                   cmd_valid,
  output logic                                   cmd_ready,
  input  logic                                   cmd_write,
  input  logic [C_M_AXI_LITE_ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [C_M_AXI_LITE_DATA_WIDTH-1:0]     cmd_wdata,
  input  logic [C_M_AXI_LITE_DATA_WIDTH/8-1:0]   cmd_wstrb,
  output logic                                   rsp_valid,
  input  logic                                   rsp_ready,
  output logic                                   rsp_write,
  output logic [C_M_AXI_LITE_DATA_WIDTH-1:0]     rsp_rdata,
  output logic [1:0]                             rsp_resp,
  // AXI-Lite master port
  output logic                                   m_axi_lite_awvalid,
  input  logic                                   m_axi_lite_awready,
  output logic [C_M_AXI_LITE_ADDR_WIDTH-1:0]     m_axi_lite_awaddr,
  output logic                                   m_axi_lite_wvalid,
  input  logic                                   m_axi_lite_wready,
  output logic [C_M_AXI_LITE_DATA_WIDTH-1:0]     m_axi_lite_wdata,
  output logic [C_M_AXI_LITE_DATA_WIDTH/8-1:0]   m_axi_lite_wstrb,
  input  logic                                   m_axi_lite_bvalid,
  output logic                                   m_axi_lite_bready,
  input  logic [1:0]                             m_axi_lite_bresp,
  output logic                                   m_axi_lite_arvalid,
  input  logic                                   m_axi_lite_arready,
  output logic [C_M_AXI_LITE_ADDR_WIDTH-1:0]     m_axi_lite_araddr,
  input  logic                                   m_axi_lite_rvalid,
  output logic                                   m_axi_lite_rready,
  input  logic [C_M_AXI_LITE_DATA_WIDTH-1:0]     m_axi_lite_rdata,
  input  logic [1:0]                             m_axi_lite_rresp,
  // status
  output logic                                   busy,
  output logic                                   timeout_err
);

  localparam int AW = C_M_AXI_LITE_ADDR_WIDTH;
  localparam int DW = C_M_AXI_LITE_DATA_WIDTH;
  localparam int SW = C_M_AXI_LITE_DATA_WIDTH / 8;
  localparam logic        TO_EN   = (C_TIMEOUT_CYCLES != 0);
  localparam logic [15:0] TO_LIM  = 16'(C_TIMEOUT_CYCLES);
  // With the timeout disabled the counter still saturates rather than wrapping.
  localparam logic [15:0] CNT_MAX = TO_EN ? TO_LIM : 16'hFFFF;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_AW_W = 3'd1,
    S_WR_B    = 3'd2,
    S_RD_AR   = 3'd3,
    S_RD_R    = 3'd4,
    S_RSP     = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [SW-1:0]   wstrb_q, wstrb_d;
  logic            awvalid_q, awvalid_d;
  logic            wvalid_q, wvalid_d;
  logic            bready_q, bready_d;
  logic            arvalid_q, arvalid_d;
  logic            rready_q, rready_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic            rsp_write_q, rsp_write_d;
  logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [1:0]      rsp_resp_q, rsp_resp_d;
  logic [15:0]     cnt_q, cnt_d;
  logic            timeout_q, timeout_d;

  logic            aw_left_s;
  logic            w_left_s;
  logic            hs_any_s;
  logic            stall_state_s;

  always_ff @(posedge m_axi_lite_aclk) begin
    if (!axi_resetn) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= 2'b00;
      cnt_q       <= 16'd0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
      cnt_q       <= cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_write_d = rsp_write_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;
    cnt_d       = cnt_q;
    timeout_d   = timeout_q;

    aw_left_s = awvalid_q & ~m_axi_lite_awready;
    w_left_s  = wvalid_q & ~m_axi_lite_wready;
    hs_any_s  = (awvalid_q & m_axi_lite_awready) | (wvalid_q & m_axi_lite_wready) |
                (m_axi_lite_bvalid & bready_q) | (arvalid_q & m_axi_lite_arready) |
                (m_axi_lite_rvalid & rready_q);
    stall_state_s = (state_q == S_WR_AW_W) || (state_q == S_WR_B) ||
                    (state_q == S_RD_AR) || (state_q == S_RD_R);

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          wstrb_d = cmd_wstrb;
          if (cmd_write) begin
            state_d   = S_WR_AW_W;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = S_RD_AR;
            arvalid_d = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WR_AW_W: begin
        // AW and W retire independently; B is only accepted once both are gone.
        awvalid_d = aw_left_s;
        wvalid_d  = w_left_s;
        if (!aw_left_s && !w_left_s) begin
          state_d  = S_WR_B;
          bready_d = 1'b1;
        end else begin
          state_d = S_WR_AW_W;
        end
      end
      S_WR_B: begin
        if (m_axi_lite_bvalid) begin
          state_d     = S_RSP;
          bready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_write_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_resp_d  = m_axi_lite_bresp;
        end else begin
          state_d = S_WR_B;
        end
      end
      S_RD_AR: begin
        if (m_axi_lite_arready) begin
          state_d   = S_RD_R;
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
        end else begin
          state_d = S_RD_AR;
        end
      end
      S_RD_R: begin
        if (m_axi_lite_rvalid) begin
          state_d     = S_RSP;
          rready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_write_d = 1'b0;
          rsp_rdata_d = m_axi_lite_rdata;
          rsp_resp_d  = m_axi_lite_rresp;
        end else begin
          state_d = S_RD_R;
        end
      end
      S_RSP: begin
        if (rsp_ready) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b0;
        end else begin
          state_d = S_RSP;
        end
      end
      default: begin
        state_d     = S_IDLE;
        awvalid_d   = 1'b0;
        wvalid_d    = 1'b0;
        bready_d    = 1'b0;
        arvalid_d   = 1'b0;
        rready_d    = 1'b0;
        rsp_valid_d = 1'b0;
      end
    endcase

    // Stall counter: any channel handshake counts as progress.
    if ((state_q == S_IDLE) || hs_any_s) begin
      cnt_d = 16'd0;
    end else if (stall_state_s && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 16'd1;
    end else begin
      cnt_d = cnt_q;
    end

    if (TO_EN && stall_state_s && (cnt_d == TO_LIM)) begin
      timeout_d = 1'b1;
    end else begin
      timeout_d = timeout_q;
    end
  end

  assign cmd_ready          = (state_q == S_IDLE);
  assign busy               = (state_q != S_IDLE);
  assign timeout_err        = timeout_q;
  assign rsp_valid          = rsp_valid_q;
  assign rsp_write          = rsp_write_q;
  assign rsp_rdata          = rsp_rdata_q;
  assign rsp_resp           = rsp_resp_q;
  assign m_axi_lite_awvalid = awvalid_q;
  assign m_axi_lite_awaddr  = addr_q;
  assign m_axi_lite_wvalid  = wvalid_q;
  assign m_axi_lite_wdata   = wdata_q;
  assign m_axi_lite_wstrb   = wstrb_q;
  assign m_axi_lite_bready  = bready_q;
  assign m_axi_lite_arvalid = arvalid_q;
  assign m_axi_lite_araddr  = addr_q;
  assign m_axi_lite_rready  = rready_q;

endmodule

// File: tb/tb_axi_lite_master.sv
// Directed bench for axi_lite_master: a small memory-backed slave, a response
// scoreboard queue, and immediate-assertion checks sampled on the falling edge.
module tb_axi_lite_master;

  logic        clk = 1'b0;
  logic        axi_resetn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [9:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_write;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [9:0]  awaddr, araddr;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        arvalid, arready, rvalid, rready;
  logic        busy, timeout_err;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        w;
    logic [31:0] rdata;
    logic [1:0]  resp;
  } exp_t;
  exp_t        sb[$];
  logic [31:0] mem [0:255];
  bit          exp_to = 1'b0;
  int          waited;

  always #5 clk = ~clk;

  axi_lite_master #(
    .C_M_AXI_LITE_ADDR_WIDTH(10),
    .C_M_AXI_LITE_DATA_WIDTH(32),
    .C_TIMEOUT_CYCLES(16)
  ) dut (
    .m_axi_lite_aclk(clk),         .axi_resetn(axi_resetn),
    .cmd_valid(cmd_valid),         .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),         .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata),         .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid),         .rsp_ready(rsp_ready),
    .rsp_write(rsp_write),         .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp),
    .m_axi_lite_awvalid(awvalid),  .m_axi_lite_awready(awready),
    .m_axi_lite_awaddr(awaddr),
    .m_axi_lite_wvalid(wvalid),    .m_axi_lite_wready(wready),
    .m_axi_lite_wdata(wdata),      .m_axi_lite_wstrb(wstrb),
    .m_axi_lite_bvalid(bvalid),    .m_axi_lite_bready(bready),
    .m_axi_lite_bresp(bresp),
    .m_axi_lite_arvalid(arvalid),  .m_axi_lite_arready(arready),
    .m_axi_lite_araddr(araddr),
    .m_axi_lite_rvalid(rvalid),    .m_axi_lite_rready(rready),
    .m_axi_lite_rdata(rdata),      .m_axi_lite_rresp(rresp),
    .busy(busy),                   .timeout_err(timeout_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called on a falling edge; returns on the falling edge after acceptance.
  task automatic send_cmd(input logic w, input logic [9:0] a, input logic [31:0] d,
                          input logic [3:0] s, input logic [31:0] exp_rdata,
                          input logic [1:0] exp_resp, output int nwait);
    exp_t e;
    nwait = 0;
    while (cmd_ready !== 1'b1 && nwait < 100) begin
      @(negedge clk);
      nwait++;
    end
    chk("cmd_ready_seen", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    e.w = w; e.rdata = w ? 32'h0 : exp_rdata; e.resp = exp_resp;
    sb.push_back(e);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic slave_write(input int aw_dly, input int w_dly, input logic [1:0] br,
                             input logic [9:0] ea, input logic [31:0] ed, input logic [3:0] es);
    bit aw_done = 1'b0;
    bit w_done  = 1'b0;
    int n = 0;
    while (!(aw_done && w_done) && n < 100) begin
      chk("awvalid", awvalid, !aw_done);
      if (!aw_done) chk("awaddr", awaddr, ea);
      chk("wvalid", wvalid, !w_done);
      if (!w_done) begin
        chk("wdata", wdata, ed);
        chk("wstrb", wstrb, es);
      end
      chk("bready_early", bready, 0);
      awready = !aw_done && (n >= aw_dly);
      wready  = !w_done && (n >= w_dly);
      if (awready) aw_done = 1'b1;
      if (wready)  w_done  = 1'b1;
      @(negedge clk);
      awready = 1'b0; wready = 1'b0;
      n++;
    end
    chk("awvalid_drop", awvalid, 0);
    chk("wvalid_drop", wvalid, 0);
    for (int b = 0; b < 4; b++)
      if (es[b]) mem[ea[9:2]][8*b +: 8] = ed[8*b +: 8];
    chk("bready", bready, 1);
    chk("arvalid_vs_bready", arvalid, 0);
    bvalid = 1'b1; bresp = br;
    @(negedge clk);
    bvalid = 1'b0; bresp = 2'b00;
    chk("bready_drop", bready, 0);
  endtask

  task automatic slave_read(input int ar_dly, input logic [1:0] rr, input logic [9:0] ea,
                            input bit to_mode);
    bit ar_done = 1'b0;
    int n = 0;
    while (!ar_done && n < 200) begin
      chk("arvalid", arvalid, 1);
      chk("araddr", araddr, ea);
      chk("rready_early", rready, 0);
      chk("bready_vs_arvalid", bready, 0);
      if (to_mode) chk("timeout_rise", timeout_err, (n >= 16) ? 1 : 0);
      arready = (n >= ar_dly);
      ar_done = arready;
      @(negedge clk);
      arready = 1'b0;
      n++;
    end
    chk("arvalid_drop", arvalid, 0);
    chk("rready", rready, 1);
    rvalid = 1'b1; rdata = mem[ea[9:2]]; rresp = rr;
    @(negedge clk);
    rvalid = 1'b0; rdata = 32'h0; rresp = 2'b00;
    chk("rready_drop", rready, 0);
  endtask

  task automatic get_rsp(input int hold, input bit expect_now);
    exp_t e;
    int n = 0;
    while (rsp_valid !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("rsp_valid", rsp_valid, 1);
    if (expect_now) chk("rsp_latency", n, 0);
    chk("sb_nonempty", (sb.size() > 0) ? 1 : 0, 1);
    e = sb.pop_front();
    for (int i = 0; i < hold; i++) begin
      chk("hold_rsp_valid", rsp_valid, 1);
      chk("hold_rsp_rdata", rsp_rdata, e.rdata);
      chk("hold_rsp_resp", rsp_resp, e.resp);
      chk("hold_cmd_ready", cmd_ready, 0);
      chk("hold_busy", busy, 1);
      @(negedge clk);
    end
    chk("rsp_write", rsp_write, e.w);
    chk("rsp_rdata", rsp_rdata, e.rdata);
    chk("rsp_resp", rsp_resp, e.resp);
    chk("timeout_err", timeout_err, exp_to);
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("rsp_valid_drop", rsp_valid, 0);
    chk("cmd_ready_after", cmd_ready, 1);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[4] = 32'h0000_0004;  // AES status register at 0x10
    axi_resetn = 1'b0; rsp_ready = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 10'h0; cmd_wdata = 32'h0; cmd_wstrb = 4'h0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
    arready = 1'b0; rvalid = 1'b0; rdata = 32'h0; rresp = 2'b00;
    repeat (3) @(negedge clk);

    // reset values
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_valids", {awvalid, wvalid, bready, arvalid, rready, rsp_valid}, 6'b0);
    chk("rst_busy", busy, 0);
    chk("rst_timeout", timeout_err, 0);
    chk("rst_rsp", {rsp_write, rsp_rdata, rsp_resp}, 35'h0);
    axi_resetn = 1'b1;
    @(negedge clk);

    // write 0x3C: W accepted at once, AW two cycles late
    send_cmd(1'b1, 10'h03C, 32'hDEAD_BEEF, 4'hF, 32'h0, 2'b00, waited);
    chk("busy_wr", busy, 1);
    slave_write(2, 0, 2'b00, 10'h03C, 32'hDEAD_BEEF, 4'hF);
    get_rsp(0, 1'b1);

    // read of AES status register
    send_cmd(1'b0, 10'h010, 32'h0, 4'h0, 32'h0000_0004, 2'b00, waited);
    slave_read(0, 2'b00, 10'h010, 1'b0);
    get_rsp(0, 1'b1);

    // back-to-back write 0x04 then read 0x3C, zero-wait slave
    send_cmd(1'b1, 10'h004, 32'h1234_5678, 4'hF, 32'h0, 2'b00, waited);
    slave_write(0, 0, 2'b00, 10'h004, 32'h1234_5678, 4'hF);
    get_rsp(0, 1'b1);
    send_cmd(1'b0, 10'h03C, 32'h0, 4'h0, 32'hDEAD_BEEF, 2'b00, waited);
    chk("b2b_accept_wait", waited, 0);
    slave_read(0, 2'b00, 10'h03C, 1'b0);
    get_rsp(0, 1'b1);

    // partial strobes, AW before W, DECERR passthrough, then read back
    send_cmd(1'b1, 10'h020, 32'hAABB_CCDD, 4'b0101, 32'h0, 2'b11, waited);
    slave_write(0, 3, 2'b11, 10'h020, 32'hAABB_CCDD, 4'b0101);
    get_rsp(0, 1'b1);
    send_cmd(1'b0, 10'h020, 32'h0, 4'h0, 32'h00BB_00DD, 2'b00, waited);
    slave_read(1, 2'b00, 10'h020, 1'b0);
    get_rsp(0, 1'b0);

    // SLVERR read held unconsumed for 20 cycles
    rsp_ready = 1'b0;
    send_cmd(1'b0, 10'h004, 32'h0, 4'h0, 32'h1234_5678, 2'b10, waited);
    slave_read(0, 2'b10, 10'h004, 1'b0);
    get_rsp(20, 1'b0);

    // AR stalled past the 16-cycle timeout, then completes
    send_cmd(1'b0, 10'h010, 32'h0, 4'h0, 32'h0000_0004, 2'b00, waited);
    slave_read(24, 2'b00, 10'h010, 1'b1);
    exp_to = 1'b1;
    get_rsp(0, 1'b0);

    // reset in the middle of a write address phase
    send_cmd(1'b1, 10'h008, 32'h5555_AAAA, 4'hF, 32'h0, 2'b00, waited);
    chk("pre_rst_awvalid", awvalid, 1);
    axi_resetn = 1'b0;
    void'(sb.pop_back());
    @(negedge clk);
    chk("mid_rst_valids", {awvalid, wvalid}, 2'b00);
    chk("mid_rst_cmd_ready", cmd_ready, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_timeout", timeout_err, 0);
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    axi_resetn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("post_rst_quiet", {rsp_valid, awvalid, wvalid, arvalid, busy}, 5'b0);
    end
    chk("sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi_lite_master.md
Name: axi_lite_master

Overview:
- Single-outstanding AXI4-Lite initiator.
- Converts a simple command/response handshake from local control logic (register-init sequencer, debug bridge) into AXI-Lite read or write transactions.
- Drives the AXI-Lite slave ports of peer cores, e.g. the AES block's status/control register space.
- Includes a sticky no-progress timeout flag for debug.

Parameters:
- C_M_AXI_LITE_ADDR_WIDTH, 10, address width of command and AW/AR channels.
- C_M_AXI_LITE_DATA_WIDTH, 32, data width; byte-strobe width is DATA_WIDTH/8.
- C_TIMEOUT_CYCLES, 1024, stall cycles before timeout_err sets; 0 disables timeout; maximum 65535.

Ports:
- m_axi_lite_aclk  in  1  clock
- axi_resetn  in  1  synchronous active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_write  in  1  1=write, 0=read
- cmd_addr  in  ADDR_WIDTH  byte address
- cmd_wdata  in  DATA_WIDTH  write data
- cmd_wstrb  in  DATA_WIDTH/8  write byte strobes
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed
- rsp_write  out  1  echo of cmd_write
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes
- rsp_resp  out  2  BRESP or RRESP
- m_axi_lite_awvalid/awready/awaddr  out/in/out  1/1/ADDR_WIDTH  AW channel
- m_axi_lite_wvalid/wready/wdata/wstrb  out/in/out/out  1/1/DATA_WIDTH/DATA_WIDTH/8  W channel
- m_axi_lite_bvalid/bready/bresp  in/out/in  1/1/2  B channel
- m_axi_lite_arvalid/arready/araddr  out/in/out  1/1/ADDR_WIDTH  AR channel
- m_axi_lite_rvalid/rready/rdata/rresp  in/out/in/in  1/1/DATA_WIDTH/2  R channel
- busy  out  1  high in any state except IDLE
- timeout_err  out  1  sticky stall flag

Behaviour:
- Clock and reset: one clock, m_axi_lite_aclk. Reset axi_resetn is synchronous and active-low; all state updates on the rising edge.
- Reset values:
  - State goes to IDLE.
  - All valid/ready outputs 0, except cmd_ready=1.
  - rsp_* = 0, busy=0, timeout_err=0, timeout counter=0.
- Output registering: all AXI outputs are registered, with no combinational path from AXI inputs to AXI outputs. cmd_ready is 1 only in IDLE (decoded from state).
- IDLE: on cmd_valid&cmd_ready, latch addr, wdata, wstrb and write.
  - write=1 -> WR_AW_W; awvalid=1 and wvalid=1 from the next cycle.
  - write=0 -> RD_AR; arvalid=1 from the next cycle.
- WR_AW_W:
  - awvalid and wvalid are tracked independently.
  - Each drops the cycle after its own handshake. Both handshakes in the same cycle is legal.
  - awaddr/wdata/wstrb are held stable while the corresponding valid is high.
  - When both have completed -> WR_B with bready=1.
- WR_B: on bvalid&bready, capture bresp, set rsp_rdata=0 and rsp_write=1, bready=0 -> RSP.
- RD_AR: araddr held stable while arvalid=1. On arvalid&arready, arvalid=0, rready=1 -> RD_R.
- RD_R: on rvalid&rready, capture rdata and rresp, set rsp_write=0, rready=0 -> RSP.
- RSP:
  - rsp_valid=1, rsp_* held stable until rsp_ready.
  - On the rsp handshake, rsp_valid=0 -> IDLE; a new command is acceptable on the following cycle.
  - rsp_ready held low stalls indefinitely with no AXI activity.
- Valid stability: no valid is ever withdrawn before its handshake. bready and rready are asserted only after the corresponding address phase completes.
- Ordering: a single transaction is outstanding; reads and writes are never overlapped.
- Minimum latency, zero-wait slave: write = cmd accept (cycle 0), AW/W handshake (cycle 1), B (cycle 2), rsp_valid (cycle 3). Reads are the same.
- Timeout counter (16-bit):
  - Increments each cycle in WR_AW_W, WR_B, RD_AR or RD_R.
  - Clears on any AXI handshake and on entry to IDLE.
  - On reaching C_TIMEOUT_CYCLES, timeout_err=1 and the counter saturates.
  - The transaction continues; AXI forbids abandoning it.
  - timeout_err clears only on reset.
- Response codes: rsp_resp passes SLVERR/DECERR through unchanged; no retry.
- Reset mid-transaction: all valids drop on the next edge and the captured command is discarded; there is no response.

Test Plan:
- Write addr 0x3C, wdata 0xDEADBEEF, wstrb 0xF; slave wready same cycle, awready 2 cycles late, bresp=0 -> wvalid drops first, awvalid held with awaddr=0x3C until handshake, rsp_valid with rsp_write=1, rsp_resp=0, rsp_rdata=0.
- Read addr 0x10 against the AES register slave -> araddr=0x10, rsp_rdata=0x00000004, rsp_resp=0, rsp_write=0.
- Back-to-back write 0x04 then read 0x3C, rsp_ready tied 1 -> second cmd accepted the cycle after the first rsp handshake; read returns 0xDEADBEEF; arvalid never overlaps bready.
- rsp_ready held 0 for 20 cycles after a read with rresp=2'b10 -> rsp_valid/rsp_rdata/rsp_resp=2'b10 stable for all 20 cycles; cmd_ready=0; busy=1.
- C_TIMEOUT_CYCLES=16, slave never asserts arready -> timeout_err=1 exactly 16 cycles after arvalid rises; arvalid stays 1; a later arready completes normally and timeout_err stays 1.
- axi_resetn=0 while awvalid=1 -> next edge: awvalid=wvalid=0, cmd_ready=1, busy=0, timeout_err=0, no rsp_valid.
